dff_debounce: RTL and testbench

- Stage directly downstream of the dff3 flop.
- Consumes the flop's registered single-bit output and filters glitches, accepting a new level only after it has been stable for a programmable number of clocks.
- Produces a clean level, one-cycle rise and fall strobes, and a wrapping count of rising events.
- Feeds the bench monitors and later control logic.

---
 rtl/dff_debounce.sv | 124 ++++++++++++
 tb/tb_dff_debounce.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dff_debounce.sv
// Glitch filter for the dff3 flop output: accepts a new level only after it has held
// for STABLE_CYCLES consecutive samples. Produces rise/fall strobes and a wrapping rise counter.
module dff_debounce #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             din,
   input  logic             cnt_clr,
   output logic             level_o,
   output logic             rise_o,
   output logic             fall_o,
   output logic [CNT_W-1:0] evt_cnt,
   output logic             busy
);

   localparam int STAB_W = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
   // Comparing against N-1 avoids widening stab for the "stab+1 == N" test.
   localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {S_LOW, S_CHK_HI, S_HIGH, S_CHK_LO} state_t;

   state_t            state_q, state_d;
   logic [STAB_W-1:0] stab_q, stab_d;
   logic              level_q, level_d;
   logic              rise_q, rise_d;
   logic              fall_q, fall_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_LOW;
         stab_q  <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         stab_q  <= stab_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      stab_d  = stab_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
         S_LOW: begin
            if (din) begin
               if (STABLE_CYCLES == 1) begin
                  state_d = S_HIGH;
                  level_d = 1'b1;
                  rise_d  = 1'b1;
               end else begin
                  state_d = S_CHK_HI;
                  stab_d  = STAB_W'(1);
               end
            end
         end
         S_CHK_HI: begin
            if (!din) begin
               state_d = S_LOW;
               stab_d  = '0;
            end else if (stab_q == STAB_LAST) begin
               state_d = S_HIGH;
               level_d = 1'b1;
               rise_d  = 1'b1;
               stab_d  = '0;
            end else begin
               stab_d = stab_q + STAB_W'(1);
            end
         end
         S_HIGH: begin
            if (!din) begin
               if (STABLE_CYCLES == 1) begin
                  state_d = S_LOW;
                  level_d = 1'b0;
                  fall_d  = 1'b1;
               end else begin
                  state_d = S_CHK_LO;
                  stab_d  = STAB_W'(1);
               end
            end
         end
         S_CHK_LO: begin
            if (din) begin
               state_d = S_HIGH;
               stab_d  = '0;
            end else if (stab_q == STAB_LAST) begin
               state_d = S_LOW;
               level_d = 1'b0;
               fall_d  = 1'b1;
               stab_d  = '0;
            end else begin
               stab_d = stab_q + STAB_W'(1);
            end
         end
         default: begin
            state_d = S_LOW;
            stab_d  = '0;
         end
      endcase

      // Clear takes precedence over a coincident rising acceptance.
      if (cnt_clr)     cnt_d = '0;
      else if (rise_d) cnt_d = cnt_q + CNT_W'(1);
      else             cnt_d = cnt_q;
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;
   assign evt_cnt = cnt_q;
   assign busy    = (state_q == S_CHK_HI) || (state_q == S_CHK_LO);

endmodule

// File: tb/tb_dff_debounce.sv
// Bench for dff_debounce: directed scenarios plus random din runs against a run-length model.
`timescale 1ns/1ps
module tb_dff_debounce;

   logic       clk = 1'b0;
   logic       reset, din, cnt_clr;
   logic       u4_level, u4_rise, u4_fall, u4_busy;
   logic [3:0] u4_cnt;
   logic       u1_level, u1_rise, u1_fall, u1_busy;
   logic [7:0] u1_cnt;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dff_debounce #(.STABLE_CYCLES(4), .CNT_W(4)) u4 (
      .clk(clk), .reset(reset), .din(din), .cnt_clr(cnt_clr),
      .level_o(u4_level), .rise_o(u4_rise), .fall_o(u4_fall),
      .evt_cnt(u4_cnt), .busy(u4_busy));

   dff_debounce #(.STABLE_CYCLES(1), .CNT_W(8)) u1 (
      .clk(clk), .reset(reset), .din(din), .cnt_clr(cnt_clr),
      .level_o(u1_level), .rise_o(u1_rise), .fall_o(u1_fall),
      .evt_cnt(u1_cnt), .busy(u1_busy));

   // Model: a new level is accepted once din has differed from it for n consecutive samples.
   typedef struct {
      bit level;
      bit rise;
      bit fall;
      int run;
      int cnt;
   } mdl_t;

   mdl_t m4 = '{0, 0, 0, 0, 0};
   mdl_t m1 = '{0, 0, 0, 0, 0};

   function automatic mdl_t mstep(mdl_t m, bit rst, bit d, bit clr, int n, int w);
      mdl_t r = m;
      r.rise = 0;
      r.fall = 0;
      if (rst) begin
         r.level = 0; r.run = 0; r.cnt = 0;
         return r;
      end
      if (d != m.level) begin
         r.run = m.run + 1;
         if (r.run == n) begin
            r.level = d; r.rise = d; r.fall = !d; r.run = 0;
         end
      end else begin
         r.run = 0;
      end
      if (clr)         r.cnt = 0;
      else if (r.rise) r.cnt = (m.cnt + 1) % (1 << w);
      return r;
   endfunction

   always @(posedge clk) begin
      m4 <= mstep(m4, reset, din, cnt_clr, 4, 4);
      m1 <= mstep(m1, reset, din, cnt_clr, 1, 8);
   end

   function automatic logic [11:0] dut4();
      return {u4_level, u4_rise, u4_fall, u4_busy, 4'b0, u4_cnt};
   endfunction
   function automatic logic [11:0] exp4();
      return {m4.level, m4.rise, m4.fall, (m4.run != 0), 8'(m4.cnt)};
   endfunction
   function automatic logic [11:0] dut1();
      return {u1_level, u1_rise, u1_fall, u1_busy, u1_cnt};
   endfunction
   function automatic logic [11:0] exp1();
      return {m1.level, m1.rise, m1.fall, (m1.run != 0), 8'(m1.cnt)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; din = 1'b0; cnt_clr = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (i == 2) reset = 1'b0;
         n_cmp++;
         if (dut4() !== 12'h000) begin
            n_err++; $display("FAIL reset_u4[%0d]: got %h expected %h", i, dut4(), 12'h000);
         end
         n_cmp++;
         if (dut1() !== 12'h000) begin
            n_err++; $display("FAIL reset_u1[%0d]: got %h expected %h", i, dut1(), 12'h000);
         end
      end
   endtask

   task automatic test_rise();
      din = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_cmp++;
         if ({u4_busy, u4_rise, u4_level, u4_fall} !== {(i < 3), (i == 3), (i >= 3), 1'b0}) begin
            n_err++;
            $display("FAIL rise_u4[%0d]: got busy/rise/level/fall %b%b%b%b expected %b%b%b0", i,
                     u4_busy, u4_rise, u4_level, u4_fall, (i < 3), (i == 3), (i >= 3));
         end
         n_cmp++;
         if ({u1_busy, u1_rise, u1_level} !== {1'b0, (i == 0), 1'b1}) begin
            n_err++;
            $display("FAIL rise_u1[%0d]: got busy/rise/level %b%b%b expected 0%b1", i,
                     u1_busy, u1_rise, u1_level, (i == 0));
         end
      end
      n_cmp++;
      if (u4_cnt !== 4'd1) begin
         n_err++; $display("FAIL rise_cnt: got %0d expected 1", u4_cnt);
      end
   endtask

   task automatic test_glitch();
      int cnt0;
      din = 1'b0;
      repeat (5) tick();
      cnt0 = m4.cnt;
      din = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if ({u4_busy, u4_rise, u4_level} !== 3'b100) begin
            n_err++;
            $display("FAIL glitch_hold[%0d]: got busy/rise/level %b%b%b expected 100", i,
                     u4_busy, u4_rise, u4_level);
         end
      end
      din = 1'b0;
      tick();
      n_cmp++;
      if ({u4_busy, u4_rise, u4_level, u4_fall, u4_cnt} !== {4'b0000, 4'(cnt0)}) begin
         n_err++;
         $display("FAIL glitch_drop: got busy/rise/level/fall %b%b%b%b cnt %0d expected 0000 cnt %0d",
                  u4_busy, u4_rise, u4_level, u4_fall, u4_cnt, cnt0);
      end
   endtask

   task automatic test_fall();
      int cnt0;
      din = 1'b1;
      repeat (5) tick();
      cnt0 = m4.cnt;
      din = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         n_cmp++;
         if ({u4_fall, u4_level, u4_busy, u4_rise, u4_cnt} !==
             {(i == 3), (i < 3), (i < 3), 1'b0, 4'(cnt0)}) begin
            n_err++;
            $display("FAIL fall[%0d]: got fall/level/busy/rise %b%b%b%b cnt %0d expected %b%b%b0 cnt %0d",
                     i, u4_fall, u4_level, u4_busy, u4_rise, u4_cnt, (i == 3), (i < 3), (i < 3), cnt0);
         end
      end
   endtask

   task automatic test_wrap();
      din = 1'b0; cnt_clr = 1'b1;
      repeat (5) tick();
      cnt_clr = 1'b0;
      n_cmp++;
      if (u4_cnt !== 4'd0) begin
         n_err++; $display("FAIL wrap_clr: got %0d expected 0", u4_cnt);
      end
      for (int k = 1; k <= 17; k++) begin
         din = 1'b1;
         repeat (4) tick();
         n_cmp++;
         if ({u4_rise, u4_cnt} !== {1'b1, 4'(k % 16)}) begin
            n_err++;
            $display("FAIL wrap[%0d]: got rise %b cnt %0d expected rise 1 cnt %0d", k, u4_rise, u4_cnt, k % 16);
         end
         din = 1'b0;
         repeat (4) tick();
      end
      din = 1'b1;
      repeat (3) tick();
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      n_cmp++;
      if ({u4_rise, u4_cnt} !== {1'b1, 4'd0}) begin
         n_err++;
         $display("FAIL clr_vs_rise: got rise %b cnt %0d expected rise 1 cnt 0", u4_rise, u4_cnt);
      end
      din = 1'b0;
      repeat (5) tick();
   endtask

   task automatic test_reset_mid();
      din = 1'b1;
      repeat (2) tick();
      n_cmp++;
      if ({u4_busy, u4_rise, u4_level} !== 3'b100) begin
         n_err++;
         $display("FAIL rmid_pre: got busy/rise/level %b%b%b expected 100", u4_busy, u4_rise, u4_level);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_cmp++;
      if (dut4() !== 12'h000) begin
         n_err++; $display("FAIL rmid_reset: got %h expected %h", dut4(), 12'h000);
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         n_cmp++;
         if ({u4_rise, u4_level, u4_busy} !== {(i == 3), (i >= 3), (i < 3)}) begin
            n_err++;
            $display("FAIL rmid[%0d]: got rise/level/busy %b%b%b expected %b%b%b", i,
                     u4_rise, u4_level, u4_busy, (i == 3), (i >= 3), (i < 3));
         end
      end
   endtask

   task automatic test_random();
      int runleft = 0;
      for (int i = 0; i < 800; i++) begin
         if (runleft == 0) begin
            din = ~din;
            runleft = $urandom_range(1, 7);
         end
         runleft--;
         cnt_clr = ($urandom % 20) == 0;
         reset   = ($urandom % 150) == 0;
         tick();
         n_cmp++;
         if (dut4() !== exp4()) begin
            n_err++; $display("FAIL rand_u4[%0d]: got %h expected %h", i, dut4(), exp4());
         end
         n_cmp++;
         if (dut1() !== exp1()) begin
            n_err++; $display("FAIL rand_u1[%0d]: got %h expected %h", i, dut1(), exp1());
         end
      end
      reset = 1'b0; cnt_clr = 1'b0;
   endtask

   initial begin
      reset = 1'b1; din = 1'b0; cnt_clr = 1'b0;
      test_reset();
      test_rise();
      test_glitch();
      test_fall();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
